// File: rtl/shape_draw_pkg.sv
// Shared command/FSM types, default geometry and the circle octant mapping
// used by the shape rasteriser.
package draw_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'b00,
        CIRCLE = 2'b01,
        RECT   = 2'b10,
        NOP    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EMIT = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int DEF_H_RES   = 320;
    localparam int DEF_V_RES   = 240;
    localparam int DEF_COORD_W = 9;
    localparam int DEF_COLOR_W = 3;
    localparam int DEF_ADDR_W  = 17;

    // swap: use (y,x) instead of (x,y); neg_x/neg_y: negate the column/row offset
    typedef struct packed {
        logic swap;
        logic neg_x;
        logic neg_y;
    } oct_map_t;

    function automatic oct_map_t octant_map(input logic [2:0] oct);
        oct_map_t m;
        case (oct)
            3'd0:    m = 3'b000;
            3'd1:    m = 3'b100;
            3'd2:    m = 3'b010;
            3'd3:    m = 3'b110;
            3'd4:    m = 3'b011;
            3'd5:    m = 3'b111;
            3'd6:    m = 3'b001;
            3'd7:    m = 3'b101;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/shape_draw_pixel_addr_gen.sv
// Bounds check and linear frame address for one signed pixel coordinate.
module pixel_addr_gen
    import draw_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int PIX_W  = DEF_COORD_W + 2,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic signed [PIX_W-1:0] col,
    input  logic signed [PIX_W-1:0] row,
    output logic                    in_bounds,
    output logic [ADDR_W-1:0]       addr
);

    logic [PIX_W-1:0] col_u_s;
    logic [PIX_W-1:0] row_u_s;

    assign col_u_s = $unsigned(col);
    assign row_u_s = $unsigned(row);

    // Negative coordinates show up as a set sign bit and are rejected first
    assign in_bounds = !col[PIX_W-1] && !row[PIX_W-1] &&
                       (col_u_s < PIX_W'(H_RES)) && (row_u_s < PIX_W'(V_RES));

    assign addr = ADDR_W'(row_u_s) * ADDR_W'(H_RES) + ADDR_W'(col_u_s);

endmodule

// File: rtl/shape_draw.sv
// Command-driven rasteriser: clear, midpoint circle outline or filled rectangle,
// one clipped pixel per cycle onto a back-pressured frame-memory write port.
module shape_draw
    import draw_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int COORD_W = DEF_COORD_W,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] size_a,
    input  logic [COORD_W-1:0] size_b,
    input  logic [COLOR_W-1:0] color,
    input  logic               wr_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    // Pixel coordinates need room for origin + extent and for negative circle points
    localparam int PW = COORD_W + 2;
    localparam int DW = COORD_W + 3;

    state_t                   state_r, state_nxt_s;
    mode_t                    mode_r;
    logic signed [PW-1:0]     org_x_r, org_y_r;
    logic [PW-1:0]            ext_w_r, ext_h_r;
    logic [COORD_W-1:0]       radius_r;
    logic [COLOR_W-1:0]       color_r;

    logic [PW-1:0]            col_cnt_r, row_cnt_r, col_cnt_nxt_s, row_cnt_nxt_s;
    logic signed [PW-1:0]     cx_r, cy_r, cx_nxt_s, cy_nxt_s;
    logic signed [DW-1:0]     d_r, d_nxt_s;
    logic [2:0]               oct_r, oct_nxt_s;

    logic signed [PW-1:0]     step_x_s, step_y_s;
    logic signed [DW-1:0]     step_d_s;
    logic                     accept_s, advance_s, rect_empty_s;
    logic                     rect_col_end_s, rect_last_s, circ_last_s, last_s;
    logic                     emit_load_s;

    oct_map_t                 oct_map_s;
    logic signed [PW-1:0]     ax_s, ay_s, off_x_s, off_y_s;
    logic signed [PW-1:0]     pix_col_s, pix_row_s;
    logic                     pix_in_s;
    logic [ADDR_W-1:0]        pix_addr_s;

    logic                     wr_en_r, busy_r, done_r;
    logic [ADDR_W-1:0]        wr_addr_r;
    logic [COLOR_W-1:0]       wr_data_r;

    assign accept_s       = (state_r == IDLE) && start;
    // A clipped pixel never waits on the memory
    assign advance_s      = (state_r == EMIT) && (!wr_en_r || wr_ready);
    assign rect_empty_s   = (ext_w_r == {PW{1'b0}}) || (ext_h_r == {PW{1'b0}});
    assign rect_col_end_s = (col_cnt_r == ext_w_r - PW'(1));
    assign rect_last_s    = rect_col_end_s && (row_cnt_r == ext_h_r - PW'(1));
    assign circ_last_s    = (oct_r == 3'd7) && (step_x_s > step_y_s);
    assign last_s         = (mode_r == CIRCLE) ? circ_last_s : rect_last_s;
    assign emit_load_s    = (state_nxt_s == EMIT) && ((state_r == LOAD) || advance_s);

    // Midpoint decision update applied after the eighth octant point
    always_comb begin
        step_x_s = cx_r + PW'(1);
        if (d_r[DW-1]) begin
            step_y_s = cy_r;
            step_d_s = d_r + (DW'(cx_r) <<< 1) + DW'(3);
        end else begin
            step_y_s = cy_r - PW'(1);
            step_d_s = d_r + ((DW'(cx_r) - DW'(cy_r)) <<< 1) + DW'(5);
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (mode == NOP) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if ((mode_r != CIRCLE) && rect_empty_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            EMIT: begin
                if (advance_s && last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the scan counters and circle state
    always_comb begin
        col_cnt_nxt_s = col_cnt_r;
        row_cnt_nxt_s = row_cnt_r;
        cx_nxt_s      = cx_r;
        cy_nxt_s      = cy_r;
        d_nxt_s       = d_r;
        oct_nxt_s     = oct_r;
        case (state_r)
            LOAD: begin
                col_cnt_nxt_s = {PW{1'b0}};
                row_cnt_nxt_s = {PW{1'b0}};
                cx_nxt_s      = {PW{1'b0}};
                cy_nxt_s      = $signed({2'b00, radius_r});
                d_nxt_s       = DW'(1) - $signed({3'b000, radius_r});
                oct_nxt_s     = 3'd0;
            end
            EMIT: begin
                if (advance_s) begin
                    if (mode_r == CIRCLE) begin
                        oct_nxt_s = oct_r + 3'd1;
                        if (oct_r == 3'd7) begin
                            cx_nxt_s = step_x_s;
                            cy_nxt_s = step_y_s;
                            d_nxt_s  = step_d_s;
                        end else begin
                            cx_nxt_s = cx_r;
                        end
                    end else if (rect_col_end_s) begin
                        col_cnt_nxt_s = {PW{1'b0}};
                        row_cnt_nxt_s = row_cnt_r + PW'(1);
                    end else begin
                        col_cnt_nxt_s = col_cnt_r + PW'(1);
                    end
                end else begin
                    oct_nxt_s = oct_r;
                end
            end
            default: oct_nxt_s = oct_r;
        endcase
    end

    // Coordinate of the pixel the next counter values point at
    always_comb begin
        oct_map_s = octant_map(oct_nxt_s);
        if (oct_map_s.swap) begin
            ax_s = cy_nxt_s;
            ay_s = cx_nxt_s;
        end else begin
            ax_s = cx_nxt_s;
            ay_s = cy_nxt_s;
        end
        off_x_s = oct_map_s.neg_x ? -ax_s : ax_s;
        off_y_s = oct_map_s.neg_y ? -ay_s : ay_s;
        if (mode_r == CIRCLE) begin
            pix_col_s = org_x_r + off_x_s;
            pix_row_s = org_y_r + off_y_s;
        end else begin
            pix_col_s = org_x_r + $signed(col_cnt_nxt_s);
            pix_row_s = org_y_r + $signed(row_cnt_nxt_s);
        end
    end

    pixel_addr_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .PIX_W  (PW),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .col       (pix_col_s),
        .row       (pix_row_s),
        .in_bounds (pix_in_s),
        .addr      (pix_addr_s)
    );

    // Command latch and scan/circle state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r    <= CLEAR;
            color_r   <= {COLOR_W{1'b0}};
            radius_r  <= {COORD_W{1'b0}};
            org_x_r   <= {PW{1'b0}};
            org_y_r   <= {PW{1'b0}};
            ext_w_r   <= {PW{1'b0}};
            ext_h_r   <= {PW{1'b0}};
            col_cnt_r <= {PW{1'b0}};
            row_cnt_r <= {PW{1'b0}};
            cx_r      <= {PW{1'b0}};
            cy_r      <= {PW{1'b0}};
            d_r       <= {DW{1'b0}};
            oct_r     <= 3'd0;
        end else begin
            if (accept_s) begin
                mode_r   <= mode_t'(mode);
                color_r  <= color;
                radius_r <= size_a;
                // Clear is a full-frame rectangle anchored at the origin
                if (mode == CLEAR) begin
                    org_x_r <= {PW{1'b0}};
                    org_y_r <= {PW{1'b0}};
                    ext_w_r <= PW'(H_RES);
                    ext_h_r <= PW'(V_RES);
                end else begin
                    org_x_r <= $signed({2'b00, x0});
                    org_y_r <= $signed({2'b00, y0});
                    ext_w_r <= {2'b00, size_a};
                    ext_h_r <= {2'b00, size_b};
                end
            end
            col_cnt_r <= col_cnt_nxt_s;
            row_cnt_r <= row_cnt_nxt_s;
            cx_r      <= cx_nxt_s;
            cy_r      <= cy_nxt_s;
            d_r       <= d_nxt_s;
            oct_r     <= oct_nxt_s;
        end
    end

    // Registered write port and status; write fields hold while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {COLOR_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == LOAD) || (state_nxt_s == EMIT);
            done_r <= (state_nxt_s == DONE);
            if (emit_load_s) begin
                wr_en_r   <= pix_in_s;
                wr_addr_r <= pix_in_s ? pix_addr_s : {ADDR_W{1'b0}};
                wr_data_r <= pix_in_s ? color_r : {COLOR_W{1'b0}};
            end else if (state_nxt_s != EMIT) begin
                wr_en_r   <= 1'b0;
                wr_addr_r <= {ADDR_W{1'b0}};
                wr_data_r <= {COLOR_W{1'b0}};
            end
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_shape_draw.sv
// Directed bench for shape_draw: a plain-integer pixel-list model drives a
// per-cycle compare process; literal address lists pin the model.
module tb_shape_draw;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [8:0]  x0, y0, size_a, size_b;
    logic [2:0]  color;
    logic        wr_ready;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [2:0]  wr_data;
    logic        busy;
    logic        done;

    shape_draw dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .x0       (x0),
        .y0       (y0),
        .size_a   (size_a),
        .size_b   (size_b),
        .color    (color),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit inb;
        int addr;
    } pix_t;

    pix_t exp_q[$];
    int   wr_log[$];
    int   exp_color;
    int   done_at;
    int   k;
    int   tail;
    bit   mon_on;
    int   checks;
    int   errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_pix(input int col, input int row);
        pix_t p;
        p.inb  = (col >= 0) && (col < 320) && (row >= 0) && (row < 240);
        p.addr = p.inb ? row * 320 + col : 0;
        exp_q.push_back(p);
    endtask

    // Pixel sequence in emission order, straight from the drawing rules
    task automatic build_model(input int m, input int x, input int y, input int a, input int b);
        exp_q.delete();
        done_at = -1;
        case (m)
            0: begin
                for (int r = 0; r < 240; r++)
                    for (int c = 0; c < 320; c++) add_pix(c, r);
            end
            1: begin
                int px, py, d;
                px = 0; py = a; d = 1 - a;
                while (px <= py) begin
                    add_pix(x + px, y + py); add_pix(x + py, y + px);
                    add_pix(x - px, y + py); add_pix(x - py, y + px);
                    add_pix(x - px, y - py); add_pix(x - py, y - px);
                    add_pix(x + px, y - py); add_pix(x + py, y - px);
                    if (d < 0) d = d + 2 * px + 3;
                    else begin
                        d = d + 2 * (px - py) + 5;
                        py = py - 1;
                    end
                    px = px + 1;
                end
            end
            2: begin
                for (int r = 0; r < b; r++)
                    for (int c = 0; c < a; c++) add_pix(x + c, y + r);
                if (a == 0 || b == 0) done_at = 2;
            end
            default: done_at = 1;
        endcase
    endtask

    // Per-cycle compare against the model, sampled on the falling edge
    initial begin : compare
        pix_t e;
        forever begin
            @(negedge clock);
            if (mon_on) begin
                k++;
                if (tail > 0) begin
                    chk("after_done_busy", busy, 0);
                    chk("after_done_pulse", done, 0);
                    chk("after_done_wr_en", wr_en, 0);
                    tail--;
                    if (tail == 0) mon_on = 1'b0;
                end else if (k == done_at) begin
                    chk("done_pulse", done, 1);
                    chk("done_busy", busy, 0);
                    chk("done_wr_en", wr_en, 0);
                    chk("pixels_left", exp_q.size(), 0);
                    tail = 3;
                end else if (k >= 2 && exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("emit_busy", busy, 1);
                    chk("emit_done", done, 0);
                    chk("wr_en", wr_en, int'(e.inb));
                    if (e.inb) begin
                        chk("wr_addr", wr_addr, e.addr);
                        chk("wr_data", wr_data, exp_color);
                    end
                    if (wr_en && wr_ready) wr_log.push_back(int'(wr_addr));
                    if (!e.inb || wr_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_at = k + 1;
                    end
                end else begin
                    chk("load_busy", busy, 1);
                    chk("load_done", done, 0);
                    chk("load_wr_en", wr_en, 0);
                end
            end
        end
    end

    task automatic run_cmd(input int m, input int x, input int y, input int a, input int b,
                           input int c, input bit rnd_ready, input bit poke_busy);
        int bound;
        build_model(m, x, y, a, b);
        exp_color = c;
        wr_log.delete();
        bound = 4 * exp_q.size() + 40;
        @(negedge clock);
        mode = 2'(m); x0 = 9'(x); y0 = 9'(y); size_a = 9'(a); size_b = 9'(b);
        color = 3'(c); start = 1'b1;
        @(posedge clock);
        k = 0; tail = 0; mon_on = 1'b1;
        #1;
        start = 1'b0;
        mode = 2'($urandom_range(0, 3)); x0 = 9'($urandom_range(0, 511));
        y0 = 9'($urandom_range(0, 511)); size_a = 9'($urandom_range(0, 511));
        size_b = 9'($urandom_range(0, 511)); color = 3'($urandom_range(0, 7));
        wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < bound && mon_on; cyc++) begin
            @(posedge clock);
            #1;
            wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (poke_busy && cyc == 3) || (done == 1'b1);
        end
        start = 1'b0;
        wr_ready = 1'b1;
        if (mon_on) begin
            chk("timeout", 1, 0);
            mon_on = 1'b0;
        end
    endtask

    initial begin
        int rect_exp[4];
        int nb_exp[4];
        int cnt;
        checks = 0; errors = 0; mon_on = 1'b0; k = 0; tail = 0; done_at = -1;
        reset = 1'b1; start = 1'b0; mode = 2'b00; x0 = 9'd0; y0 = 9'd0;
        size_a = 9'd0; size_b = 9'd0; color = 3'd0; wr_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge clock); #1 reset = 1'b0;

        run_cmd(3, 5, 5, 5, 5, 7, 1'b0, 1'b0);           // reserved mode: done at N+1
        chk("nop_writes", wr_log.size(), 0);
        run_cmd(2, 10, 10, 5, 0, 2, 1'b0, 1'b0);         // empty rectangle: done at N+2
        chk("empty_rect_writes", wr_log.size(), 0);

        run_cmd(2, 318, 10, 4, 2, 6, 1'b0, 1'b0);
        rect_exp = '{3518, 3519, 3838, 3839};
        chk("rect_clip_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rect_clip_addr", (i < wr_log.size()) ? wr_log[i] : -1, rect_exp[i]);

        run_cmd(1, 160, 120, 0, 0, 3, 1'b0, 1'b0);
        chk("circle_r0_count", wr_log.size(), 8);
        foreach (wr_log[i]) chk("circle_r0_addr", wr_log[i], 38560);

        run_cmd(1, 160, 120, 1, 0, 4, 1'b0, 1'b0);
        nb_exp = '{38240, 38559, 38561, 38880};
        chk("circle_r1_count", wr_log.size(), 8);
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            foreach (wr_log[j]) if (wr_log[j] == nb_exp[i]) cnt++;
            chk("circle_r1_dup", cnt, 2);
        end

        run_cmd(1, 160, 120, 10, 0, 1, 1'b1, 1'b1);      // stalls plus start while busy
        run_cmd(2, 2, 1, 5, 3, 2, 1'b1, 1'b1);
        run_cmd(1, 3, 3, 6, 0, 7, 1'b1, 1'b0);           // clipped on the left/top edges

        // Reset partway through a circle aborts it silently
        @(negedge clock);
        mode = 2'b01; x0 = 9'd160; y0 = 9'd120; size_a = 9'd10; color = 3'd5; start = 1'b1;
        @(posedge clock); #1 start = 1'b0; wr_ready = 1'b1;
        repeat (15) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("mid_busy", busy, 1);
        @(posedge clock);
        @(negedge clock);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("post_abort_done", done, 0);
            chk("post_abort_busy", busy, 0);
        end
        run_cmd(2, 100, 50, 3, 2, 3, 1'b0, 1'b0);

        run_cmd(0, 0, 0, 0, 0, 5, 1'b0, 1'b0);           // full-frame clear
        chk("clear_count", wr_log.size(), 76800);
        chk("clear_first", (wr_log.size() > 0) ? wr_log[0] : -1, 0);
        chk("clear_last", (wr_log.size() > 0) ? wr_log[wr_log.size() - 1] : -1, 76799);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shape_draw.md
# shape_draw

Parametrised pixel rasteriser that writes shapes into the dual-port frame memory on its write port while the VGA scan-out reads the other port. It accepts one command at a time: clear screen, midpoint circle outline, or filled rectangle. It emits one clipped pixel write per accepted cycle and signals completion. It is the command-driven successor to the fixed single-circle drawer, with runtime geometry, colour, modes and write back-pressure.

## Interface
- `H_RES`, 320: frame width in pixels.
- `V_RES`, 240: frame height in pixels.
- `COORD_W`, 9: width of coordinate and size fields.
- `COLOR_W`, 3: pixel colour width.
- `ADDR_W`, 17: frame memory address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command strobe; accepted only in IDLE.
- `mode` in 2: 00 clear, 01 circle outline, 10 filled rectangle, 11 reserved (treated as no-op).
- `x0`, `y0` in COORD_W each: circle centre, or rectangle top-left corner.
- `size_a` in COORD_W: circle radius, or rectangle width.
- `size_b` in COORD_W: rectangle height; ignored in other modes.
- `color` in COLOR_W: pixel value.
- `wr_ready` in 1: memory accepts a write this cycle.
- `wr_en` out 1: write strobe.
- `wr_addr` out ADDR_W: pixel address.
- `wr_data` out COLOR_W: pixel data.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- Command fields are latched on acceptance. Later changes to the inputs have no effect until the next acceptance.
- `start` is ignored while `busy` is high.
- Address is `row*H_RES + col`, computed in ADDR_W bits.
- Clipping: a pixel with col >= H_RES, row >= V_RES, or a negative coordinate produces no write. It still consumes one cycle, with `wr_en` low and no wait on `wr_ready`.
- **Clear mode:** writes all H_RES*V_RES pixels in raster order, address 0 upward.
- **Rectangle mode:** scans rows y0..y0+size_b-1, and within each row columns x0..x0+size_a-1, in raster order. If size_a = 0 or size_b = 0, there are no writes.
- **Circle mode:** midpoint algorithm.
  - Initialise x=0, y=r, d=1-r. d is signed, COORD_W+3 bits.
  - While x <= y, emit 8 octant points in the fixed order (+x,+y), (+y,+x), (-x,+y), (-y,+x), (-x,-y), (-y,-x), (+x,-y), (+y,-x), each offset from the centre. Emit one point per cycle.
  - After the 8th point: if d < 0, then d += 2x+3; otherwise d += 2(x-y)+5 and y--. Then x++.
  - Duplicate points at x=0 and at x==y are written, not suppressed.
- **FSM states:**
  - IDLE → (start & mode≠11) LOAD.
  - IDLE → (start & mode=11) DONE.
  - LOAD → EMIT: sets up counters and d.
  - EMIT → EMIT while pixels remain; advances only when the current pixel is clipped or `wr_ready` is high.
  - EMIT → DONE after the last pixel advances.
  - LOAD → DONE directly for an empty rectangle.
  - DONE → IDLE unconditionally.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, FSM in IDLE.
- `start` is sampled at edge N. `busy` is high from N+1 until the cycle before `done`.
- The first `wr_en` can be high at N+2 (after LOAD).
- Outputs are registered. `wr_en`, `wr_addr` and `wr_data` hold stable while `wr_en`=1 and `wr_ready`=0.
- A write completes on an edge where `wr_en` and `wr_ready` are both high.
- Throughput is one pixel per cycle with `wr_ready` held high.
- `done` is high for exactly one cycle, the cycle after the last pixel advances. `busy`=0 in that cycle.
- A `start` sampled during DONE is ignored; the next command is accepted from IDLE.
- Reset mid-command aborts on the next edge. All outputs return to reset values and no `done` pulse is produced.

## Structure
- Package `draw_pkg`: `mode_t` enum (CLEAR, CIRCLE, RECT, NOP), `state_t` enum (IDLE, LOAD, EMIT, DONE), and the default resolution constants.
- Sub-module `pixel_addr_gen`: signed col/row in; in-bounds flag and ADDR_W address out; purely combinational, parametrised by H_RES/V_RES.
- Top level holds the FSM, rectangle/clear counters, circle x/y/d registers and the octant index (3 bits).

## Test plan
- Clear, colour 3'b101, `wr_ready`=1 → 76800 writes at addresses 0..76799, all data 5; `done` at N+2+76800; no later `wr_en`.
- Rectangle x0=318, y0=10, size_a=4, size_b=2 → writes only (318,10), (319,10), (318,11), (319,11), i.e. addresses 3518, 3519, 3838, 3839; 8 emit cycles total; `done` afterwards.
- Circle centre (160,120), r=0 → 8 writes, all to address 38560; r=1 → 8 writes to the 4-neighbour addresses 38240, 38559, 38561, 38880, each written twice.
- Circle r=10 at (160,120), with `wr_ready` toggled randomly → write set equals the reference midpoint set; outputs stable while stalled.
- Rectangle size_b=0 → `done` at N+2 with no writes. Mode 11 → `done` at N+1.
- Reset asserted mid-circle → next cycle all outputs 0, no `done`. A new `start` afterwards completes normally. `start` while `busy` is ignored.
